// File: rtl/core_wb_bridge.sv
// rtl/core_wb_bridge.sv - core memory port to single-outstanding Wishbone-classic master bridge
//
// Turns the core's handshake-free memory port into one Wishbone-classic access at a time.
// The core is held by core_stall_o until the access ends. A timeout bounds every access,
// so a slave that never acks cannot hang the core.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   core_req_i/addr/wdata/we/wstrb core access request
//   core_rdata_o                   load data, updated only when a read completes
//   core_stall_o                   core must hold while high (combinational)
//   core_done_o                    one-cycle pulse, access finished
//   wb_cyc_o/stb/we/sel/addr/data  Wishbone master outputs (registered)
//   wb_data_i/ack_i/err_i          Wishbone slave response
//   err_o                          sticky error/timeout flag
module core_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    input  logic                    core_we_i,
    input  logic [DATA_WIDTH/8-1:0] core_wstrb_i,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    core_stall_o,
    output logic                    core_done_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    err_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    // A zero-width counter is illegal, so a disabled timeout still keeps one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign wb_stb_o    = wb_cyc_o;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ack, err and timeout all finish the access
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (core_req_i) state_nxt = S_BUS;
            S_BUS:  if (wb_ack_i || wb_err_i || timeout_hit) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Core-facing outputs decoded from state
    always_comb begin
        core_stall_o = 1'b0;
        core_done_o  = 1'b0;
        case (state)
            S_IDLE:  core_stall_o = core_req_i;
            S_BUS:   core_stall_o = 1'b1;
            S_DONE:  core_done_o  = 1'b1;
            default: ;
        endcase
    end

    // Bus outputs, timeout counter, read data and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_cyc_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            core_rdata_o <= '0;
            err_o        <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_req_i) begin
                        wb_cyc_o  <= 1'b1;
                        wb_we_o   <= core_we_i;
                        wb_sel_o  <= core_we_i ? core_wstrb_i : {SEL_W{1'b1}};
                        wb_addr_o <= core_addr_i;
                        wb_data_o <= core_wdata_i;
                        cnt       <= '0;
                    end
                end
                S_BUS: begin
                    if (wb_ack_i) begin
                        if (!wb_we_o) core_rdata_o <= wb_data_i;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                    end else if (wb_err_i || timeout_hit) begin
                        if (!wb_we_o) core_rdata_o <= ERR_DATA;
                        err_o    <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        // Saturate rather than wrap when the timeout is disabled
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_wb_bridge.sv
// tb/tb_core_wb_bridge.sv - directed-vector bench for core_wb_bridge
module tb_core_wb_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic        core_we_i;
    logic [3:0]  core_wstrb_i;
    logic [31:0] core_rdata_o;
    logic        core_stall_o;
    logic        core_done_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        err_o;

    int vectors     = 0;
    int miscompares = 0;

    core_wb_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8),
        .ERR_DATA      (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req_i  (core_req_i),
        .core_addr_i (core_addr_i),
        .core_wdata_i(core_wdata_i),
        .core_we_i   (core_we_i),
        .core_wstrb_i(core_wstrb_i),
        .core_rdata_o(core_rdata_o),
        .core_stall_o(core_stall_o),
        .core_done_o (core_done_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_data_i   (wb_data_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 ns after the rising edge and checked 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        core_req_i   = 1'b1;
        core_addr_i  = addr;
        core_we_i    = we;
        core_wdata_i = wdata;
        core_wstrb_i = wstrb;
    endtask

    int n_cyc;
    int n_done;

    initial begin
        reset = 1'b1;
        core_req_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
        core_we_i = 1'b0; core_wstrb_i = '0;
        wb_data_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

        // Reset state
        #12;
        check_vec("rst_cyc",   wb_cyc_o, 0);
        check_vec("rst_stb",   wb_stb_o, 0);
        check_vec("rst_we",    wb_we_o, 0);
        check_vec("rst_sel",   wb_sel_o, 0);
        check_vec("rst_addr",  wb_addr_o, 0);
        check_vec("rst_rdata", core_rdata_o, 0);
        check_vec("rst_done",  core_done_o, 0);
        check_vec("rst_err",   err_o, 0);
        check_vec("rst_stall", core_stall_o, 0);
        tick();
        reset = 1'b0;
        tick();

        // Read, zero-wait slave
        request(32'h100, 1'b0, 32'h0, 4'h0);
        #1;
        check_vec("rd_stall_req", core_stall_o, 1);
        check_vec("rd_cyc_pre",   wb_cyc_o, 0);
        tick();
        core_req_i = 1'b0;
        wb_ack_i = 1'b1; wb_data_i = 32'h1234_5678;
        #1;
        check_vec("rd_cyc",   wb_cyc_o, 1);
        check_vec("rd_stb",   wb_stb_o, 1);
        check_vec("rd_stall", core_stall_o, 1);
        check_vec("rd_sel",   wb_sel_o, 4'hF);
        check_vec("rd_addr",  wb_addr_o, 32'h100);
        check_vec("rd_we",    wb_we_o, 0);
        check_vec("rd_done0", core_done_o, 0);
        tick();
        wb_ack_i = 1'b0;
        #1;
        check_vec("rd_done",  core_done_o, 1);
        check_vec("rd_cyc_end", wb_cyc_o, 0);
        check_vec("rd_stall_done", core_stall_o, 0);
        check_vec("rd_rdata", core_rdata_o, 32'h1234_5678);
        tick();
        #1;
        check_vec("rd_done_low", core_done_o, 0);
        check_vec("rd_rdata_hold", core_rdata_o, 32'h1234_5678);

        // Write, 3 wait states
        request(32'h200, 1'b1, 32'hA5A5_A5A5, 4'b0011);
        tick();
        core_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_ack_i = (i == 3);
            #1;
            check_vec($sformatf("wr_we_%0d", i),    wb_we_o, 1);
            check_vec($sformatf("wr_cyc_%0d", i),   wb_cyc_o, 1);
            check_vec($sformatf("wr_stall_%0d", i), core_stall_o, 1);
            check_vec($sformatf("wr_sel_%0d", i),   wb_sel_o, 4'b0011);
            check_vec($sformatf("wr_data_%0d", i),  wb_data_o, 32'hA5A5_A5A5);
            tick();
        end
        wb_ack_i = 1'b0;
        #1;
        check_vec("wr_done",  core_done_o, 1);
        check_vec("wr_we_end", wb_we_o, 0);
        check_vec("wr_rdata", core_rdata_o, 32'h1234_5678);
        tick();

        // Simultaneous ack and err: ack wins
        request(32'h104, 1'b0, 32'h0, 4'h0);
        tick();
        core_req_i = 1'b0;
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_data_i = 32'hCAFE_F00D;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        #1;
        check_vec("ae_done",  core_done_o, 1);
        check_vec("ae_rdata", core_rdata_o, 32'hCAFE_F00D);
        check_vec("ae_err",   err_o, 0);
        tick();

        // Timeout after 8 BUS cycles
        request(32'h300, 1'b0, 32'h0, 4'h0);
        tick();
        core_req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_vec($sformatf("to_cyc_%0d", i), wb_cyc_o, 1);
            tick();
        end
        #1;
        check_vec("to_cyc_end", wb_cyc_o, 0);
        check_vec("to_done",    core_done_o, 1);
        check_vec("to_rdata",   core_rdata_o, 32'hDEAD_BEEF);
        check_vec("to_err",     err_o, 1);
        tick();

        // Good read afterwards keeps err_o set
        request(32'h108, 1'b0, 32'h0, 4'h0);
        tick();
        core_req_i = 1'b0;
        wb_ack_i = 1'b1; wb_data_i = 32'h0BAD_F00D;
        tick();
        wb_ack_i = 1'b0;
        #1;
        check_vec("post_rdata", core_rdata_o, 32'h0BAD_F00D);
        check_vec("post_err",   err_o, 1);
        tick();

        // Reset during BUS
        request(32'h400, 1'b0, 32'h0, 4'h0);
        tick();
        core_req_i = 1'b0;
        #1;
        check_vec("rb_cyc", wb_cyc_o, 1);
        reset = 1'b1;
        #1;
        check_vec("rb_cyc_rst",   wb_cyc_o, 0);
        check_vec("rb_stb_rst",   wb_stb_o, 0);
        check_vec("rb_stall_rst", core_stall_o, 0);
        check_vec("rb_err_rst",   err_o, 0);
        tick();
        reset = 1'b0;
        #1;
        check_vec("rb_done_none", core_done_o, 0);
        tick();
        check_vec("rb_done_none2", core_done_o, 0);
        request(32'h500, 1'b0, 32'h0, 4'h0);
        tick();
        core_req_i = 1'b0;
        wb_ack_i = 1'b1; wb_data_i = 32'h0000_55AA;
        #1;
        check_vec("rb_new_addr", wb_addr_o, 32'h500);
        tick();
        wb_ack_i = 1'b0;
        #1;
        check_vec("rb_new_done",  core_done_o, 1);
        check_vec("rb_new_rdata", core_rdata_o, 32'h0000_55AA);
        tick();

        // Back-to-back reads, ack held high throughout
        n_cyc = 0;
        n_done = 0;
        request(32'h600, 1'b0, 32'h0, 4'h0);
        wb_ack_i = 1'b1;
        wb_data_i = 32'h1000;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c % 3 == 0) wb_data_i = 32'h1000 + 32'(c / 3);
            if (c == 10) core_req_i = 1'b0;
            #1;
            check_vec($sformatf("bb_cyc_%0d", c),  wb_cyc_o, (c % 3 == 0));
            check_vec($sformatf("bb_done_%0d", c), core_done_o, (c % 3 == 1));
            if (wb_cyc_o) n_cyc++;
            if (core_done_o) begin
                n_done++;
                check_vec($sformatf("bb_rdata_%0d", c), core_rdata_o, 32'h1000 + 32'((c - 1) / 3));
            end
        end
        check_vec("bb_ncyc",  n_cyc, 4);
        check_vec("bb_ndone", n_done, 4);
        wb_err_i = 1'b1;
        tick();
        #1;
        check_vec("bb_stray_cyc", wb_cyc_o, 0);
        check_vec("bb_stray_err", err_o, 0);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
